pal_dma_ctrl: RTL and testbench
===============================

# pal_dma_ctrl

Palette transfer sequencer that owns the GA21 write port of the palette RAM. It copies a block of words from a CPU-side palette buffer, or fills a block with a constant, into palette RAM. It drives the palette RAM's GA21 request, address and write-enable plus the DMA busy flag that the palette mux uses to steal the RAM from video lookup. A transfer starts either immediately or on the next vblank rising edge.

## Interface
- ADDR_W, 13, palette RAM word-address width; addresses wrap modulo 2^ADDR_W.
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- cpu_wr  in  1  register write strobe, one cycle per write.
- cpu_reg  in  2  register select: 0 = dest start, 1 = word count, 2 = fill value, 3 = control.
- cpu_din  in  16  register write data.
- vblank  in  1  video vblank level.
- src_addr  out  ADDR_W  buffer RAM read address, registered.
- src_q  in  16  buffer RAM read data; valid the cycle after src_addr.
- pal_req  out  1  GA21 request to palette RAM mux.
- pal_we  out  1  palette RAM write enable.
- pal_addr  out  ADDR_W  palette RAM address.
- pal_data  out  16  write data: src_q in copy mode, latched fill value in fill mode (combinational select).
- busy  out  1  transfer in progress; feeds the mux DMA-busy input.
- done  out  1  one-cycle pulse at transfer completion.

## Operation
- Registers:
  - reg0[ADDR_W-1:0] holds the start address.
  - reg1[ADDR_W-1:0] holds the word count; 0 means no transfer.
  - reg2 holds the fill value.
  - reg3 is control: bit1 = fill mode, bit2 = wait-for-vblank.
  - Writing reg3 with bit0 = 1 is GO. GO is ignored while busy.
- Writes to reg0–reg2 while busy update the registers only. The active transfer uses a working copy of start, count, mode and fill value latched at GO.
- States: IDLE, WAIT_VB, PRIME, XFER.
- IDLE, on GO:
  - count = 0: stay IDLE and pulse done next cycle. No pal_req, no writes.
  - wait bit set: go to WAIT_VB.
  - copy mode: go to PRIME.
  - fill mode: go to XFER.
- WAIT_VB:
  - busy = 1, pal_req = 0.
  - Leave on a vblank rising edge (vblank = 1 now, 0 last cycle), to PRIME (copy) or XFER (fill).
  - If vblank is already high at GO, wait for the next rising edge.
- PRIME (copy only):
  - busy = 1, pal_req = 1, pal_we = 0, src_addr = start.
  - Next state XFER.
- XFER:
  - busy = 1, pal_req = 1, pal_we = 1. pal_addr = current address a.
  - Copy mode: src_addr = a+1, so the next word's read overlaps the current write.
  - a increments modulo 2^ADDR_W each cycle. The remaining count decrements.
  - After the write with remaining = 1, go to IDLE.
- Completion: in the first IDLE cycle after XFER, done = 1 for exactly one cycle and busy, pal_req and pal_we are 0.
- A vblank falling edge during XFER does not pause the transfer.
- Reset at any point: return to IDLE and drop all working state. No done pulse.

## Timing
- Reset values: src_addr = 0, pal_addr = 0, pal_req = 0, pal_we = 0, busy = 0, done = 0, all registers 0. pal_data is then 0 (fill mode 0, src_q passthrough is undefined only if src_q is).
- GO sampled at edge E0.
- Copy, no wait:
  - From E0: busy = 1, pal_req = 1, src_addr = start.
  - From E1: first write.
  - Writes occupy E1 through E(count).
  - done is high in the cycle after E(count).
  - Total busy = count+1 cycles.
- Fill, no wait: writes occupy E0 through E(count-1); busy = count cycles.
- Wait mode: PRIME or XFER entry occurs at the edge that samples the vblank rise. Timing from there matches the no-wait case.
- Throughput: one word per clock once in XFER. No ce_pix qualification.
- pal_req is asserted no later than the first pal_we, and in the same cycle as busy in all non-wait states.

## Test plan
- Copy: buffer[0x100..0x103] = 0x1111, 0x2222, 0x3333, 0x4444; reg0 = 0x100, reg1 = 4, GO copy, no wait -> pal_we high 4 consecutive cycles at 0x100..0x103 with those data, busy 5 cycles, one done pulse.
- Fill with wrap: reg0 = 0x1FFE, reg1 = 4, reg2 = 0x7C1F, GO fill -> writes to 0x1FFE, 0x1FFF, 0x0000, 0x0001, all 0x7C1F; busy 4 cycles.
- Zero count: reg1 = 0, GO -> done pulse next cycle, pal_req and pal_we never assert, busy stays 0.
- Vblank wait: GO with wait bit while vblank = 1 -> no pal_req through that vblank. vblank falls, then rises at cycle T -> writes begin at T+1 for copy.
- GO while busy and register rewrite: second GO mid-transfer, plus reg0 = 0x500 -> current transfer finishes unchanged with exactly one done, no second transfer.
- Reset mid-transfer: assert reset during the 3rd write of an 8-word copy -> the next cycle shows all outputs at reset values, no done pulse, and a subsequent GO works normally.

Source files
------------

// File: rtl/pal_dma_ctrl.sv
// Palette transfer sequencer: owns the GA21 write port of palette RAM.
// Copies a block from the CPU-side buffer RAM or fills a block with a
// constant, optionally starting on the next vblank rising edge.
module pal_dma_ctrl #(
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_wr,
  input  logic [1:0]        cpu_reg,
  input  logic [15:0]       cpu_din,
  input  logic              vblank,
  output logic [ADDR_W-1:0] src_addr,
  input  logic [15:0]       src_q,
  output logic              pal_req,
  output logic              pal_we,
  output logic [ADDR_W-1:0] pal_addr,
  output logic [15:0]       pal_data,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VB = 2'd1,
    PRIME   = 2'd2,
    XFER    = 2'd3
  } state_t;

  state_t state_reg, state_next;

  // CPU-visible registers
  logic [ADDR_W-1:0] start_reg;
  logic [ADDR_W-1:0] count_reg;
  logic [15:0]       fill_reg;

  // Working copy latched at GO; later register writes do not disturb it
  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W-1:0] remain_reg;
  logic              fill_mode_reg;
  logic [15:0]       wfill_reg;

  logic [ADDR_W-1:0] src_addr_reg;
  logic              done_reg;
  logic              vb_prev_reg;

  logic go;
  logic vb_rise;
  logic last_word;

  // Control bits above bit 2 and data bits above ADDR_W carry no meaning
  logic unused_din_bits;
  assign unused_din_bits = ^cpu_din[15:3];

  assign go        = cpu_wr && (cpu_reg == 2'd3) && cpu_din[0];
  assign vb_rise   = vblank && !vb_prev_reg;
  assign last_word = (remain_reg == ADDR_W'(1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state and port-control decode
  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    pal_req    = 1'b0;
    pal_we     = 1'b0;
    case (state_reg)
      IDLE: begin
        // A zero count never leaves IDLE; only a done pulse results
        if (go && (count_reg != '0)) begin
          if (cpu_din[2])      state_next = WAIT_VB;
          else if (cpu_din[1]) state_next = XFER;
          else                 state_next = PRIME;
        end
      end
      WAIT_VB: begin
        busy = 1'b1;
        if (vb_rise) state_next = fill_mode_reg ? XFER : PRIME;
      end
      PRIME: begin
        busy       = 1'b1;
        pal_req    = 1'b1;
        state_next = XFER;
      end
      XFER: begin
        busy    = 1'b1;
        pal_req = 1'b1;
        pal_we  = 1'b1;
        if (last_word) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Register file, working copy, address/count datapath and done pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      start_reg     <= '0;
      count_reg     <= '0;
      fill_reg      <= '0;
      addr_reg      <= '0;
      remain_reg    <= '0;
      fill_mode_reg <= 1'b0;
      wfill_reg     <= '0;
      src_addr_reg  <= '0;
      done_reg      <= 1'b0;
      vb_prev_reg   <= 1'b0;
    end else begin
      vb_prev_reg <= vblank;
      done_reg    <= 1'b0;

      if (cpu_wr) begin
        case (cpu_reg)
          2'd0:    start_reg <= cpu_din[ADDR_W-1:0];
          2'd1:    count_reg <= cpu_din[ADDR_W-1:0];
          2'd2:    fill_reg  <= cpu_din;
          default: ;
        endcase
      end

      case (state_reg)
        IDLE: begin
          if (go) begin
            if (count_reg == '0) begin
              done_reg <= 1'b1;
            end else begin
              addr_reg      <= start_reg;
              remain_reg    <= count_reg;
              fill_mode_reg <= cpu_din[1];
              wfill_reg     <= fill_reg;
              src_addr_reg  <= start_reg;
            end
          end
        end
        PRIME: begin
          // First word is being read; point at the second for the overlap
          src_addr_reg <= addr_reg + ADDR_W'(1);
        end
        XFER: begin
          addr_reg   <= addr_reg + ADDR_W'(1);
          remain_reg <= remain_reg - ADDR_W'(1);
          if (!fill_mode_reg) src_addr_reg <= addr_reg + ADDR_W'(2);
          if (last_word) done_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign src_addr = src_addr_reg;
  assign pal_addr = addr_reg;
  assign done     = done_reg;
  assign pal_data = fill_mode_reg ? wfill_reg : src_q;

endmodule

// File: tb/tb_pal_dma_ctrl.sv
// Scoreboard bench for pal_dma_ctrl: stimulus pushes expected palette
// writes / done pulses, a negedge monitor pops and compares them.
module tb_pal_dma_ctrl;

  localparam int AW = 13;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_wr;
  logic [1:0]    cpu_reg;
  logic [15:0]   cpu_din;
  logic          vblank;
  logic [AW-1:0] src_addr;
  logic [15:0]   src_q;
  logic          pal_req;
  logic          pal_we;
  logic [AW-1:0] pal_addr;
  logic [15:0]   pal_data;
  logic          busy;
  logic          done;

  pal_dma_ctrl #(.ADDR_W(AW)) dut (
    .clk      (clk),
    .reset    (reset),
    .cpu_wr   (cpu_wr),
    .cpu_reg  (cpu_reg),
    .cpu_din  (cpu_din),
    .vblank   (vblank),
    .src_addr (src_addr),
    .src_q    (src_q),
    .pal_req  (pal_req),
    .pal_we   (pal_we),
    .pal_addr (pal_addr),
    .pal_data (pal_data),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Buffer RAM model with registered read
  logic [15:0] buf_mem [0:(1<<AW)-1];
  initial src_q = 16'h0;
  always @(posedge clk) src_q <= buf_mem[src_addr];

  typedef struct packed {
    logic          is_done;
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } exp_t;

  exp_t exp_q[$];

  int tests_run  = 0;
  int fails      = 0;
  int busy_total = 0;
  int req_total  = 0;
  int done_total = 0;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests_run++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  task automatic push_wr(input logic [AW-1:0] a, input logic [15:0] d);
    exp_t e;
    e.is_done = 1'b0;
    e.addr    = a;
    e.data    = d;
    exp_q.push_back(e);
  endtask

  task automatic push_done();
    exp_t e;
    e.is_done = 1'b1;
    e.addr    = '0;
    e.data    = '0;
    exp_q.push_back(e);
  endtask

  // One register write; called just after a posedge, returns just after the next
  task automatic wr(input logic [1:0] r, input logic [15:0] d);
    cpu_wr  = 1'b1;
    cpu_reg = r;
    cpu_din = d;
    @(posedge clk); #1;
    cpu_wr  = 1'b0;
    $display("[TB] reg%0d <= %h", r, d);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    if (exp_q.size() != 0) begin
      tests_run++;
      fails++;
      $display("FAIL %s_timeout: %0d expected events still pending, expected 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (2) begin
      @(posedge clk); #1;
    end
  endtask

  // Monitor: compare every presented write / done against the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (busy)    busy_total++;
      if (pal_req) req_total++;
      if (done)    done_total++;
      if (pal_req && !busy) check_eq("req_implies_busy", 32'(busy), 32'd1);
      if (pal_we) begin
        check_eq("we_needs_req_busy", {30'd0, pal_req, busy}, 32'd3);
        tests_run++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_write: addr=%h data=%h, expected no write", pal_addr, pal_data);
        end else begin
          e = exp_q.pop_front();
          if (e.is_done) begin
            fails++;
            $display("FAIL order: got write addr=%h, expected done pulse", pal_addr);
          end else begin
            $display("[TB] write addr=%h data=%h (exp %h/%h)", pal_addr, pal_data, e.addr, e.data);
            check_eq("write_addr", 32'(pal_addr), 32'(e.addr));
            check_eq("write_data", 32'(pal_data), 32'(e.data));
          end
        end
      end
      if (done) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_done: got done=1, expected 0");
        end else begin
          e = exp_q.pop_front();
          if (!e.is_done) begin
            fails++;
            $display("FAIL order: got done, expected write addr=%h", e.addr);
          end else begin
            $display("[TB] done pulse");
          end
        end
      end
    end
  end

  int b0, r0, d0;

  initial begin
    for (int i = 0; i < (1 << AW); i++) buf_mem[i] = 16'h0;
    buf_mem[13'h100] = 16'h1111;
    buf_mem[13'h101] = 16'h2222;
    buf_mem[13'h102] = 16'h3333;
    buf_mem[13'h103] = 16'h4444;
    for (int i = 0; i < 8; i++) buf_mem[13'h200 + i] = 16'hA000 + 16'(i);

    reset   = 1'b1;
    cpu_wr  = 1'b0;
    cpu_reg = 2'd0;
    cpu_din = 16'h0;
    vblank  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_ctrl", {28'd0, busy, pal_req, pal_we, done}, 32'd0);
    check_eq("reset_src_addr", 32'(src_addr), 32'd0);
    check_eq("reset_pal_addr", 32'(pal_addr), 32'd0);
    check_eq("reset_pal_data", 32'(pal_data), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Copy 4 words from 0x100
    wr(2'd0, 16'h0100);
    wr(2'd1, 16'd4);
    push_wr(13'h100, 16'h1111);
    push_wr(13'h101, 16'h2222);
    push_wr(13'h102, 16'h3333);
    push_wr(13'h103, 16'h4444);
    push_done();
    b0 = busy_total; d0 = done_total;
    wr(2'd3, 16'h0001);
    check_eq("copy_prime_ctrl", {29'd0, busy, pal_req, pal_we}, 32'b110);
    check_eq("copy_prime_src", 32'(src_addr), 32'h100);
    @(posedge clk); #1;
    check_eq("copy_first_we", 32'(pal_we), 32'd1);
    drain("copy");
    check_eq("copy_busy_cycles", 32'(busy_total - b0), 32'd5);
    check_eq("copy_done_count", 32'(done_total - d0), 32'd1);

    // Fill 4 words with address wrap
    wr(2'd0, 16'h1FFE);
    wr(2'd1, 16'd4);
    wr(2'd2, 16'h7C1F);
    push_wr(13'h1FFE, 16'h7C1F);
    push_wr(13'h1FFF, 16'h7C1F);
    push_wr(13'h0000, 16'h7C1F);
    push_wr(13'h0001, 16'h7C1F);
    push_done();
    b0 = busy_total;
    wr(2'd3, 16'h0003);
    check_eq("fill_first_we", 32'(pal_we), 32'd1);
    check_eq("fill_first_addr", 32'(pal_addr), 32'h1FFE);
    drain("fill");
    check_eq("fill_busy_cycles", 32'(busy_total - b0), 32'd4);

    // Zero count
    wr(2'd1, 16'd0);
    push_done();
    b0 = busy_total; r0 = req_total;
    wr(2'd3, 16'h0001);
    check_eq("zero_done", 32'(done), 32'd1);
    drain("zero");
    check_eq("zero_busy_cycles", 32'(busy_total - b0), 32'd0);
    check_eq("zero_req_cycles", 32'(req_total - r0), 32'd0);

    // Vblank wait, copy 2 words; GO while vblank already high
    vblank = 1'b1;
    wr(2'd0, 16'h0100);
    wr(2'd1, 16'd2);
    push_wr(13'h100, 16'h1111);
    push_wr(13'h101, 16'h2222);
    push_done();
    r0 = req_total;
    wr(2'd3, 16'h0005);
    repeat (4) begin
      @(posedge clk); #1;
    end
    check_eq("vb_wait_busy", 32'(busy), 32'd1);
    check_eq("vb_wait_no_req", 32'(req_total - r0), 32'd0);
    vblank = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    vblank = 1'b1;
    @(posedge clk); #1;
    check_eq("vb_prime_ctrl", {30'd0, pal_req, pal_we}, 32'b10);
    vblank = 1'b0;
    @(posedge clk); #1;
    check_eq("vb_first_we_addr", {19'd0, pal_we, pal_addr}, {19'd0, 1'b1, 13'h100});
    drain("vblank");
    check_eq("vb_req_cycles", 32'(req_total - r0), 32'd3);

    // GO while busy plus register rewrite mid-transfer
    wr(2'd0, 16'h0300);
    wr(2'd1, 16'd6);
    wr(2'd2, 16'h1234);
    for (int i = 0; i < 6; i++) push_wr(13'h300 + 13'(i), 16'h1234);
    push_done();
    b0 = busy_total; d0 = done_total;
    wr(2'd3, 16'h0003);
    wr(2'd3, 16'h0003);
    wr(2'd0, 16'h0500);
    wr(2'd1, 16'd1);
    drain("busy_go");
    check_eq("busy_go_cycles", 32'(busy_total - b0), 32'd6);
    check_eq("busy_go_done_count", 32'(done_total - d0), 32'd1);
    push_wr(13'h500, 16'h1234);
    push_done();
    wr(2'd3, 16'h0003);
    drain("rewritten_regs");

    // Reset during the 3rd write of an 8-word copy
    wr(2'd0, 16'h0200);
    wr(2'd1, 16'd8);
    push_wr(13'h200, 16'hA000);
    push_wr(13'h201, 16'hA001);
    push_wr(13'h202, 16'hA002);
    wr(2'd3, 16'h0001);
    repeat (3) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    check_eq("midreset_ctrl", {28'd0, busy, pal_req, pal_we, done}, 32'd0);
    check_eq("midreset_addrs", {6'd0, src_addr, pal_addr}, 32'd0);
    check_eq("midreset_pending", 32'(exp_q.size()), 32'd0);
    reset = 1'b0;
    d0 = done_total;
    repeat (5) begin
      @(posedge clk); #1;
    end
    check_eq("midreset_no_done", 32'(done_total - d0), 32'd0);
    wr(2'd0, 16'h0204);
    wr(2'd1, 16'd2);
    push_wr(13'h204, 16'hA004);
    push_wr(13'h205, 16'hA005);
    push_done();
    wr(2'd3, 16'h0001);
    drain("after_reset");

    check_eq("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
